// File: rtl/dcache_wt_direct.sv
`default_nettype none
// ============================================================================
// Module   : dcache_wt_direct
// Purpose  : Direct-mapped, write-through, no-write-allocate data cache with
//            RISC-V byte/half/word lane handling, multi-word block refill,
//            pipeline stall, req/ack backing-memory bus and whole-cache flush.
// Revision : 1.0 - initial release
// ============================================================================

package dcache_wt_direct_pkg;

    typedef enum logic [1:0] {
        OTHER  = 2'd0,
        LOAD   = 2'd1,
        STORE  = 2'd2,
        BRANCH = 2'd3
    } InstructionTypes;

    typedef enum logic [2:0] {
        LOAD_BYTE  = 3'd0,
        LOAD_HALF  = 3'd1,
        LOAD_WORD  = 3'd2,
        ULOAD_BYTE = 3'd3,
        ULOAD_HALF = 3'd4,
        STORE_BYTE = 3'd5,
        STORE_HALF = 3'd6,
        STORE_WORD = 3'd7
    } InstructionSubTypes;

endpackage

module dcache_wt_direct
    import dcache_wt_direct_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int SETS          = 64,
    parameter int BLOCK_WORDS   = 4
) (
    input  logic                     iClk,
    input  logic                     iRstN,
    input  InstructionTypes          iInstructionType,
    input  InstructionSubTypes       iMemoryInstructionType,
    input  logic [ADDRESS_WIDTH-1:0] iAddress,
    input  logic [31:0]              iMemData,
    input  logic                     iFlush,
    output logic [31:0]              oMemData,
    output logic                     oStall,
    output logic                     oBusReq,
    output logic                     oBusWe,
    output logic [ADDRESS_WIDTH-1:0] oBusAddr,
    output logic [31:0]              oBusWData,
    output logic [3:0]               oBusByteEn,
    input  logic                     iBusAck,
    input  logic [31:0]              iBusRData
);

    // Address split: [tag | index | word offset | byte offset(2)]
    localparam int c_WO_BITS  = $clog2(BLOCK_WORDS);
    localparam int c_WO_W     = (c_WO_BITS > 0) ? c_WO_BITS : 1;
    localparam int c_IDX_W    = $clog2(SETS);
    localparam int c_OFF_BITS = 2 + c_WO_BITS;
    localparam int c_TAG_W    = ADDRESS_WIDTH - c_OFF_BITS - c_IDX_W;

    localparam logic [c_WO_W-1:0]        c_LAST_BEAT  = c_WO_W'(BLOCK_WORDS - 1);
    localparam logic [ADDRESS_WIDTH-1:0] c_BLOCK_MASK = ~ADDRESS_WIDTH'((64'd1 << c_OFF_BITS) - 64'd1);
    localparam logic [ADDRESS_WIDTH-1:0] c_WORD_MASK  = ~ADDRESS_WIDTH'(3);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_REFILL = 2'd1;
    localparam logic [1:0] c_S_WRITE  = 2'd2;

    // Cache storage: valid bits are reset, tags and data are not
    logic [SETS-1:0]    r_valid;
    logic [c_TAG_W-1:0] r_tag  [SETS];
    logic [31:0]        r_data [SETS][BLOCK_WORDS];

    // Controller state; r_addr holds the block base during refill and the
    // word-aligned store address during a write
    logic [1:0]               r_state;
    logic [1:0]               w_state_next;
    logic [c_WO_W-1:0]        r_cnt;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [31:0]              r_wdata;
    logic [3:0]               r_wbe;

    logic [1:0]         w_byte_off;
    logic [c_WO_W-1:0]  w_req_wo;
    logic [c_IDX_W-1:0] w_req_idx;
    logic [c_TAG_W-1:0] w_req_tag;
    logic [c_WO_W-1:0]  w_lat_wo;
    logic [c_IDX_W-1:0] w_lat_idx;
    logic [c_TAG_W-1:0] w_lat_tag;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_hit;
    logic [31:0] w_word;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load_fmt;
    logic [31:0] w_st_data;
    logic [3:0]  w_st_be;
    logic        w_stall;
    logic        w_start_refill;
    logic        w_start_write;
    logic        w_refill_beat;
    logic        w_refill_done;
    logic        w_write_hit_ack;

    assign w_byte_off = iAddress[1:0];
    assign w_req_idx  = iAddress[c_OFF_BITS +: c_IDX_W];
    assign w_req_tag  = iAddress[ADDRESS_WIDTH-1 -: c_TAG_W];
    assign w_lat_idx  = r_addr[c_OFF_BITS +: c_IDX_W];
    assign w_lat_tag  = r_addr[ADDRESS_WIDTH-1 -: c_TAG_W];

    generate
        if (c_WO_BITS > 0) begin : g_word_offset
            assign w_req_wo = iAddress[2 +: c_WO_W];
            assign w_lat_wo = r_addr[2 +: c_WO_W];
        end else begin : g_single_word
            assign w_req_wo = '0;
            assign w_lat_wo = '0;
        end
    endgenerate

    assign w_is_load  = (iInstructionType == LOAD);
    assign w_is_store = (iInstructionType == STORE);

    // A flush in the same cycle invalidates everything, so the access misses
    assign w_hit  = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag) && !iFlush;
    assign w_word = r_data[w_req_idx][w_req_wo];

    // Select and extend the addressed lanes of the hit word
    always_comb begin
        w_lane_byte = 8'(w_word >> {w_byte_off, 3'b000});
        w_lane_half = (w_byte_off == 2'd3) ? w_word[31:16]
                                           : 16'(w_word >> {w_byte_off, 3'b000});
        case (iMemoryInstructionType)
            LOAD_BYTE:  w_load_fmt = {{24{w_lane_byte[7]}}, w_lane_byte};
            ULOAD_BYTE: w_load_fmt = {24'h0, w_lane_byte};
            LOAD_HALF:  w_load_fmt = {{16{w_lane_half[15]}}, w_lane_half};
            ULOAD_HALF: w_load_fmt = {16'h0, w_lane_half};
            default:    w_load_fmt = w_word;
        endcase
    end

    // Position right-aligned store data into its byte lanes with enables
    always_comb begin
        w_st_data = iMemData;
        w_st_be   = 4'hF;
        case (iMemoryInstructionType)
            STORE_BYTE: begin
                w_st_data = {24'h0, iMemData[7:0]} << {w_byte_off, 3'b000};
                w_st_be   = 4'b0001 << w_byte_off;
            end
            STORE_HALF: begin
                if (w_byte_off == 2'd3) begin
                    w_st_data = {iMemData[15:0], 16'h0};
                    w_st_be   = 4'b1100;
                end else begin
                    w_st_data = {16'h0, iMemData[15:0]} << {w_byte_off, 3'b000};
                    w_st_be   = 4'b0011 << w_byte_off;
                end
            end
            default: begin
                w_st_data = iMemData;
                w_st_be   = 4'hF;
            end
        endcase
    end

    assign w_start_refill  = (r_state == c_S_IDLE) && w_is_load && !w_hit;
    assign w_start_write   = (r_state == c_S_IDLE) && w_is_store;
    assign w_refill_beat   = (r_state == c_S_REFILL) && iBusAck;
    assign w_refill_done   = w_refill_beat && (r_cnt == c_LAST_BEAT);
    assign w_write_hit_ack = (r_state == c_S_WRITE) && iBusAck && r_valid[w_lat_idx]
                             && (r_tag[w_lat_idx] == w_lat_tag);

    // Next-state and stall decode
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_start_refill) begin
                    w_stall      = 1'b1;
                    w_state_next = c_S_REFILL;
                end else if (w_start_write) begin
                    w_stall      = 1'b1;
                    w_state_next = c_S_WRITE;
                end
            end
            c_S_REFILL: begin
                w_stall = 1'b1;
                if (w_refill_done) begin
                    w_state_next = c_S_IDLE;
                end
            end
            c_S_WRITE: begin
                // Release the pipeline in the ack cycle so it advances on that edge
                w_stall = !iBusAck;
                if (iBusAck) begin
                    w_state_next = c_S_IDLE;
                end
            end
            default: begin
                w_state_next = c_S_IDLE;
            end
        endcase
    end

    // State register, beat counter and latched transaction fields
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wbe   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start_refill) begin
                r_addr <= iAddress & c_BLOCK_MASK;
                r_cnt  <= '0;
            end else if (w_start_write) begin
                r_addr  <= iAddress & c_WORD_MASK;
                r_wdata <= w_st_data;
                r_wbe   <= w_st_be;
            end else if (w_refill_beat) begin
                r_cnt <= (r_cnt == c_LAST_BEAT) ? '0 : r_cnt + 1'b1;
            end
        end
    end

    // Valid bits: flush clears all, a refill invalidates its line until complete
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_valid <= '0;
        end else if (r_state == c_S_IDLE) begin
            if (iFlush) begin
                r_valid <= '0;
            end else if (w_start_refill) begin
                r_valid[w_req_idx] <= 1'b0;
            end
        end else if (w_refill_done) begin
            r_valid[w_lat_idx] <= 1'b1;
        end
    end

    // Tag and data arrays: refill beats and write-through updates on a hit
    always_ff @(posedge iClk) begin
        if (w_refill_done) begin
            r_tag[w_lat_idx] <= w_lat_tag;
        end
        if (w_refill_beat) begin
            r_data[w_lat_idx][r_cnt] <= iBusRData;
        end
        if (w_write_hit_ack) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wbe[b]) begin
                    r_data[w_lat_idx][w_lat_wo][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    // Bus outputs decode only registered state, so they stay stable until ack
    always_comb begin
        oBusReq    = 1'b0;
        oBusWe     = 1'b0;
        oBusAddr   = '0;
        oBusWData  = '0;
        oBusByteEn = '0;
        case (r_state)
            c_S_REFILL: begin
                oBusReq    = 1'b1;
                oBusAddr   = r_addr | (ADDRESS_WIDTH'(r_cnt) << 2);
                oBusByteEn = 4'hF;
            end
            c_S_WRITE: begin
                oBusReq    = 1'b1;
                oBusWe     = 1'b1;
                oBusAddr   = r_addr;
                oBusWData  = r_wdata;
                oBusByteEn = r_wbe;
            end
            default: begin
                oBusReq = 1'b0;
            end
        endcase
    end

    assign oStall   = w_stall;
    assign oMemData = ((r_state == c_S_IDLE) && w_is_load && w_hit) ? w_load_fmt : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_dcache_wt_direct.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_wt_direct
// Purpose  : Self-checking bench for dcache_wt_direct: directed scenarios plus
//            random loads/stores/flushes against a memory + residency model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_dcache_wt_direct;
    import dcache_wt_direct_pkg::*;

    localparam int AW   = 32;
    localparam int SETS = 64;
    localparam int BW   = 4;

    logic               iClk = 1'b0;
    logic               iRstN = 1'b0;
    InstructionTypes    iInstructionType = OTHER;
    InstructionSubTypes iMemoryInstructionType = LOAD_WORD;
    logic [AW-1:0]      iAddress = '0;
    logic [31:0]        iMemData = '0;
    logic               iFlush = 1'b0;
    logic [31:0]        oMemData;
    logic               oStall;
    logic               oBusReq;
    logic               oBusWe;
    logic [AW-1:0]      oBusAddr;
    logic [31:0]        oBusWData;
    logic [3:0]         oBusByteEn;
    logic               iBusAck;
    logic [31:0]        iBusRData;

    dcache_wt_direct #(.ADDRESS_WIDTH(AW), .SETS(SETS), .BLOCK_WORDS(BW)) dut (
        .iClk                   (iClk),
        .iRstN                  (iRstN),
        .iInstructionType       (iInstructionType),
        .iMemoryInstructionType (iMemoryInstructionType),
        .iAddress               (iAddress),
        .iMemData               (iMemData),
        .iFlush                 (iFlush),
        .oMemData               (oMemData),
        .oStall                 (oStall),
        .oBusReq                (oBusReq),
        .oBusWe                 (oBusWe),
        .oBusAddr               (oBusAddr),
        .oBusWData              (oBusWData),
        .oBusByteEn             (oBusByteEn),
        .iBusAck                (iBusAck),
        .iBusRData              (iBusRData)
    );

    initial forever #5 iClk = ~iClk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } beat_t;

    // Backing memory (word-addressed), residency model (set -> block number)
    logic [31:0] mem  [int unsigned];
    int unsigned held [int unsigned];
    beat_t       beat_log [$];
    int          fixed_wait = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int unsigned wa);
        if (mem.exists(wa)) return mem[wa];
        return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] exp_load(input InstructionSubTypes s, input logic [31:0] w,
                                             input logic [1:0] o);
        int unsigned b, h, hs;
        b  = (w >> (8 * int'(o))) & 32'hFF;
        hs = (o == 2'd3) ? 2 : int'(o);
        h  = (w >> (8 * hs)) & 32'hFFFF;
        case (s)
            LOAD_BYTE:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
            ULOAD_BYTE: return b;
            LOAD_HALF:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
            ULOAD_HALF: return h;
            default:    return w;
        endcase
    endfunction

    task automatic exp_store(input InstructionSubTypes s, input logic [31:0] d, input logic [1:0] o,
                             output logic [31:0] wd, output logic [3:0] be);
        int sh;
        case (s)
            STORE_BYTE: begin
                sh = int'(o);
                be = 4'(1 << sh);
                wd = (d & 32'hFF) << (8 * sh);
            end
            STORE_HALF: begin
                sh = (o == 2'd3) ? 2 : int'(o);
                be = 4'(3 << sh);
                wd = (d & 32'hFFFF) << (8 * sh);
            end
            default: begin
                be = 4'hF;
                wd = d;
            end
        endcase
    endtask

    // Bus slave: each beat acks after fixed_wait idle cycles; outputs must hold
    initial begin : responder
        int          left;
        beat_t       cap;
        logic [31:0] cur;
        left      = -1;
        iBusAck   = 1'b0;
        iBusRData = 32'h0;
        forever begin
            @(negedge iClk);
            iBusAck   = 1'b0;
            iBusRData = 32'h0;
            if (iRstN === 1'b1 && oBusReq === 1'b1) begin
                if (left < 0) begin
                    left      = fixed_wait;
                    cap.we    = oBusWe;
                    cap.addr  = oBusAddr;
                    cap.wdata = oBusWData;
                    cap.be    = oBusByteEn;
                end else begin
                    check("bus_hold_addr", oBusAddr, cap.addr);
                    check("bus_hold_wdata", oBusWData, cap.wdata);
                    check("bus_hold_ctrl", {oBusWe, oBusByteEn}, {cap.we, cap.be});
                end
                if (left == 0) begin
                    iBusAck = 1'b1;
                    if (oBusWe) begin
                        cur = mem_rd(oBusAddr >> 2);
                        for (int b = 0; b < 4; b++)
                            if (oBusByteEn[b]) cur[8*b +: 8] = oBusWData[8*b +: 8];
                        mem[oBusAddr >> 2] = cur;
                    end else begin
                        iBusRData = mem_rd(oBusAddr >> 2);
                    end
                    beat_log.push_back(cap);
                    left = -1;
                end else begin
                    left--;
                end
            end else begin
                left = -1;
            end
        end
    end

    // One pipeline access held until oStall drops; checks timing, bus beats, data
    task automatic access(input InstructionTypes t, input InstructionSubTypes s, input logic [31:0] a,
                          input logic [31:0] d, input bit fl, input int w, output logic [31:0] got);
        int unsigned set_i, blk;
        bit          hit;
        int          exp_stalls, exp_beats, stalls;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        set_i = (a >> 4) % SETS;
        blk   = a >> 4;
        hit   = !fl && held.exists(set_i) && (held[set_i] == blk);
        if (fl) held.delete();
        if (t == LOAD) begin
            exp_beats  = hit ? 0 : BW;
            exp_stalls = hit ? 0 : 1 + BW * (w + 1);
            if (!hit) held[set_i] = blk;
        end else begin
            exp_beats  = 1;
            exp_stalls = 1 + w;
        end
        exp_store(s, d, a[1:0], exp_wd, exp_be);
        fixed_wait = w;
        beat_log.delete();

        @(negedge iClk);
        iInstructionType       = t;
        iMemoryInstructionType = s;
        iAddress               = a;
        iMemData               = d;
        iFlush                 = fl;
        #1;
        stalls = 0;
        while (oStall === 1'b1 && stalls <= 100) begin
            check("stall_data_zero", oMemData, 32'h0);
            stalls++;
            @(negedge iClk);
            iFlush = 1'b0;
            #1;
        end
        check("stall_cycles", stalls, exp_stalls);
        check("beat_count", beat_log.size(), exp_beats);
        if (t == LOAD) begin
            check("load_data", oMemData, exp_load(s, mem_rd(a >> 2), a[1:0]));
            for (int k = 0; k < beat_log.size() && k < exp_beats; k++) begin
                check("refill_addr", beat_log[k].addr, (blk << 4) + 4 * k);
                check("refill_ctrl", {beat_log[k].we, beat_log[k].be}, {1'b0, 4'hF});
            end
        end else begin
            check("store_data_zero", oMemData, 32'h0);
            if (beat_log.size() > 0) begin
                check("store_addr", beat_log[0].addr, a & 32'hFFFF_FFFC);
                check("store_wdata", beat_log[0].wdata, exp_wd);
                check("store_ctrl", {beat_log[0].we, beat_log[0].be}, {1'b1, exp_be});
            end
        end
        got    = oMemData;
        iFlush = 1'b0;
    endtask

    task automatic idle(input bit fl);
        @(negedge iClk);
        iInstructionType = OTHER;
        iFlush           = fl;
        if (fl) held.delete();
        #1;
        check("idle_stall", {oStall, oBusReq}, 2'b00);
        check("idle_data", oMemData, 32'h0);
    endtask

    initial begin : main
        logic [31:0] got, a, d;
        InstructionTypes    t;
        InstructionSubTypes s;
        int r;

        // Reset state
        #12;
        check("rst_stall", oStall, 1'b0);
        check("rst_memdata", oMemData, 32'h0);
        check("rst_busreq", {oBusReq, oBusWe}, 2'b00);
        check("rst_busaddr", oBusAddr, 32'h0);
        check("rst_buswdata", oBusWData, 32'h0);
        check("rst_busbe", oBusByteEn, 4'h0);
        @(negedge iClk);
        iRstN = 1'b1;

        // Refill from 0x100, then hit inside the same line
        mem[32'h100 >> 2] = 32'h11;
        mem[32'h104 >> 2] = 32'h22;
        mem[32'h108 >> 2] = 32'h33;
        mem[32'h10C >> 2] = 32'h44;
        access(LOAD, LOAD_WORD, 32'h100, 32'h0, 1'b0, 0, got);
        check("first_refill_word", got, 32'h11);
        access(LOAD, LOAD_WORD, 32'h108, 32'h0, 1'b0, 0, got);
        check("hit_word_108", got, 32'h33);

        // Lane extraction on 0x80FF7F01
        access(STORE, STORE_WORD, 32'h100, 32'h80FF7F01, 1'b0, 1, got);
        access(LOAD, LOAD_BYTE, 32'h103, 32'h0, 1'b0, 0, got);
        check("lb_103", got, 32'hFFFFFF80);
        access(LOAD, ULOAD_BYTE, 32'h103, 32'h0, 1'b0, 0, got);
        check("lbu_103", got, 32'h00000080);
        access(LOAD, LOAD_HALF, 32'h101, 32'h0, 1'b0, 0, got);
        check("lh_101", got, 32'hFFFFFF7F);
        access(LOAD, ULOAD_HALF, 32'h103, 32'h0, 1'b0, 0, got);
        check("lhu_103", got, 32'h000080FF);

        // Store half at offset 2 on a hit, ack after two wait cycles
        access(STORE, STORE_HALF, 32'h102, 32'h0000ABCD, 1'b0, 2, got);
        if (beat_log.size() > 0) begin
            check("sh_be", beat_log[0].be, 4'b1100);
            check("sh_wdata", beat_log[0].wdata, 32'hABCD0000);
        end
        access(LOAD, LOAD_WORD, 32'h100, 32'h0, 1'b0, 0, got);
        check("after_sh_word", got, 32'hABCD7F01);

        // Store miss does not allocate
        access(STORE, STORE_BYTE, 32'h3001, 32'h0000005A, 1'b0, 0, got);
        access(LOAD, ULOAD_BYTE, 32'h3001, 32'h0, 1'b0, 1, got);
        check("nowa_load", got, 32'h5A);

        // Flush then reload of a previously hit line
        access(LOAD, LOAD_WORD, 32'h104, 32'h0, 1'b0, 0, got);
        idle(1'b1);
        access(LOAD, LOAD_WORD, 32'h104, 32'h0, 1'b0, 0, got);

        // Reset during the second refill beat
        fixed_wait = 0;
        beat_log.delete();
        @(negedge iClk);
        iInstructionType       = LOAD;
        iMemoryInstructionType = LOAD_WORD;
        iAddress               = 32'h140;
        @(negedge iClk);
        @(negedge iClk);
        #2;
        iRstN            = 1'b0;
        iInstructionType = OTHER;
        #1;
        check("midrst_busreq", {oBusReq, oBusWe}, 2'b00);
        check("midrst_busaddr", oBusAddr, 32'h0);
        check("midrst_busbe", oBusByteEn, 4'h0);
        check("midrst_stall", oStall, 1'b0);
        @(negedge iClk);
        @(negedge iClk);
        iRstN = 1'b1;
        held.delete();
        access(LOAD, LOAD_WORD, 32'h140, 32'h0, 1'b0, 0, got);
        access(LOAD, LOAD_WORD, 32'h14C, 32'h0, 1'b0, 0, got);

        // Random mix against the model
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 19);
            a = 32'h1000 + (($urandom_range(0, 2) * SETS + $urandom_range(0, 3)) * 16)
                + $urandom_range(0, 15);
            d = $urandom;
            if (r < 10) begin
                t = LOAD;
                s = InstructionSubTypes'($urandom_range(0, 7));
            end else if (r < 18) begin
                t = STORE;
                s = ($urandom_range(0, 7) == 0) ? InstructionSubTypes'($urandom_range(0, 4))
                                                : InstructionSubTypes'($urandom_range(5, 7));
            end else begin
                t = OTHER;
                s = LOAD_WORD;
            end
            if (t == OTHER)
                idle($urandom_range(0, 1) == 1);
            else
                access(t, s, a, d, ($urandom_range(0, 15) == 0), $urandom_range(0, 3), got);
        end
        idle(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
